// File: rtl/div_tick_timer_if.sv
// Handshake/bus bundle for div_tick_timer: divider levels, control strobes and timer status.
interface div_tick_timer_if #(
  parameter int unsigned WIDTH = 8
);
  logic             divideby2;
  logic             divideby4;
  logic             divideby8;
  logic             divideby16;
  logic [1:0]       rate_sel;
  logic [WIDTH-1:0] period;
  logic             start;
  logic             stop;
  logic             ack;
  logic             tick;
  logic             busy;
  logic             expired;
  logic             expire_pulse;
  logic             overrun;
  logic [WIDTH-1:0] count;

  modport master (
    output divideby2, divideby4, divideby8, divideby16,
    output rate_sel, period, start, stop, ack,
    input  tick, busy, expired, expire_pulse, overrun, count
  );

  modport slave (
    input  divideby2, divideby4, divideby8, divideby16,
    input  rate_sel, period, start, stop, ack,
    output tick, busy, expired, expire_pulse, overrun, count
  );
endinterface

// File: rtl/div_tick_timer.sv
// Tick-enable generator and programmable down-count timer driven by clock-divider levels.
// Optional auto-reload (periodic) mode enabled by defining DIV_TICK_AUTO_RELOAD_EN.
module div_tick_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  div_tick_timer_if.slave  bus
);

  localparam int unsigned DIV_W = 4;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_EXPIRED = 2'd2;

  logic [1:0]       state_q,        state_d;
  logic [DIV_W-1:0] hist_q,         hist_d;
  logic             tick_q,         tick_d;
  logic             busy_q,         busy_d;
  logic             expired_q,      expired_d;
  logic             expire_pulse_q, expire_pulse_d;
  logic             overrun_q,      overrun_d;
  logic [WIDTH-1:0] count_q,        count_d;
  logic [WIDTH-1:0] period_q,       period_d;

  logic [DIV_W-1:0] div_lvl_c;
  logic             raw_tick_c;
  logic [WIDTH-1:0] load_val_c;

  // All histories track every cycle, so switching rate_sel never sees a stale level.
  assign div_lvl_c  = {bus.divideby16, bus.divideby8, bus.divideby4, bus.divideby2};
  assign raw_tick_c = div_lvl_c[bus.rate_sel] & ~hist_q[bus.rate_sel];
  assign load_val_c = (bus.period == '0) ? WIDTH'(1) : bus.period;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      hist_q         <= '0;
      tick_q         <= 1'b0;
      busy_q         <= 1'b0;
      expired_q      <= 1'b0;
      expire_pulse_q <= 1'b0;
      overrun_q      <= 1'b0;
      count_q        <= '0;
      period_q       <= '0;
    end else begin
      state_q        <= state_d;
      hist_q         <= hist_d;
      tick_q         <= tick_d;
      busy_q         <= busy_d;
      expired_q      <= expired_d;
      expire_pulse_q <= expire_pulse_d;
      overrun_q      <= overrun_d;
      count_q        <= count_d;
      period_q       <= period_d;
    end
  end

  // Next-state and output logic; priority stop > start > raw_tick > ack
  always_comb begin
    state_d        = state_q;
    hist_d         = div_lvl_c;
    tick_d         = raw_tick_c;
    expired_d      = expired_q;
    expire_pulse_d = 1'b0;
    overrun_d      = overrun_q;
    count_d        = count_q;
    period_d       = period_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          count_d   = load_val_c;
          period_d  = load_val_c;
          expired_d = 1'b0;
          state_d   = ST_RUN;
        end else if (bus.ack) begin
          expired_d = 1'b0;
          overrun_d = 1'b0;
        end
      end

      ST_RUN: begin
        if (bus.stop) begin
          state_d = ST_IDLE;
        end else if (bus.start) begin
          count_d  = load_val_c;
          period_d = load_val_c;
        end else if (raw_tick_c) begin
          if (count_q > WIDTH'(1)) begin
            count_d = count_q - WIDTH'(1);
          end else begin
            expired_d      = 1'b1;
            expire_pulse_d = 1'b1;
`ifdef DIV_TICK_AUTO_RELOAD_EN
            overrun_d      = overrun_q | expired_q;
            count_d        = period_q;
`else
            count_d        = '0;
            state_d        = ST_EXPIRED;
`endif
          end
        end else if (bus.ack) begin
          expired_d = 1'b0;
          overrun_d = 1'b0;
        end
      end

      ST_EXPIRED: begin
        if (bus.stop) begin
          expired_d = 1'b0;
          state_d   = ST_IDLE;
        end else if (bus.start) begin
          expired_d = 1'b0;
          count_d   = load_val_c;
          period_d  = load_val_c;
          state_d   = ST_RUN;
        end else if (bus.ack) begin
          expired_d = 1'b0;
          overrun_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

`ifndef DIV_TICK_AUTO_RELOAD_EN
    overrun_d = 1'b0;
`endif

    busy_d = (state_d == ST_RUN);
  end

  assign bus.tick         = tick_q;
  assign bus.busy         = busy_q;
  assign bus.expired      = expired_q;
  assign bus.expire_pulse = expire_pulse_q;
  assign bus.overrun      = overrun_q;
  assign bus.count        = count_q;

endmodule

// File: tb/tb_div_tick_timer.sv
// Self-checking bench for div_tick_timer: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model.
module tb_div_tick_timer;

  localparam int unsigned WIDTH = 8;

  logic clk;
  logic rst;
  logic [3:0] div_cnt;
  int n_cmp;
  int n_err;
  int cyc;

  div_tick_timer_if #(.WIDTH(WIDTH)) bus ();

  div_tick_timer #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state
  typedef enum int {M_IDLE, M_RUN, M_EXP} mstate_t;
  mstate_t m_state;
  int      m_count;
  int      m_period;
  bit      m_tick, m_busy, m_exp, m_pulse, m_ovr;
  bit [3:0] m_prev_lvl;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock of the reference: evaluates the rules on the inputs seen at this edge.
  task automatic model_step();
    bit [3:0] lvl;
    bit rise;
    int p;
    lvl  = {bus.divideby16, bus.divideby8, bus.divideby4, bus.divideby2};
    rise = lvl[bus.rate_sel] && !m_prev_lvl[bus.rate_sel];
    if (!rst) begin
      m_state = M_IDLE; m_count = 0; m_period = 0; m_prev_lvl = 4'b0;
      m_tick = 0; m_busy = 0; m_exp = 0; m_pulse = 0; m_ovr = 0;
      return;
    end
    m_prev_lvl = lvl;
    m_tick     = rise;
    m_pulse    = 0;
    p = (bus.period == 0) ? 1 : int'(bus.period);
    case (m_state)
      M_IDLE: begin
        if (bus.start) begin
          m_count = p; m_period = p; m_exp = 0; m_state = M_RUN;
        end else if (bus.ack) begin
          m_exp = 0; m_ovr = 0;
        end
      end
      M_RUN: begin
        if (bus.stop) m_state = M_IDLE;
        else if (bus.start) begin
          m_count = p; m_period = p;
        end else if (rise) begin
          if (m_count > 1) m_count = m_count - 1;
          else begin
`ifdef DIV_TICK_AUTO_RELOAD_EN
            if (m_exp) m_ovr = 1;
            m_count = m_period;
`else
            m_count = 0;
            m_state = M_EXP;
`endif
            m_exp = 1; m_pulse = 1;
          end
        end else if (bus.ack) begin
          m_exp = 0; m_ovr = 0;
        end
      end
      default: begin
        if (bus.stop) begin
          m_exp = 0; m_state = M_IDLE;
        end else if (bus.start) begin
          m_exp = 0; m_count = p; m_period = p; m_state = M_RUN;
        end else if (bus.ack) begin
          m_exp = 0; m_ovr = 0; m_state = M_IDLE;
        end
      end
    endcase
    m_busy = (m_state == M_RUN);
  endtask

  task automatic compare_all();
    chk("tick",         32'(bus.tick),         32'(m_tick));
    chk("busy",         32'(bus.busy),         32'(m_busy));
    chk("expired",      32'(bus.expired),      32'(m_exp));
    chk("expire_pulse", 32'(bus.expire_pulse), 32'(m_pulse));
    chk("overrun",      32'(bus.overrun),      32'(m_ovr));
    chk("count",        32'(bus.count),        32'(m_count));
  endtask

  // Advance one clock: model, compare, then move the divider on.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
    cyc++;
    div_cnt        = div_cnt + 4'd1;
    bus.divideby2  = div_cnt[0];
    bus.divideby4  = div_cnt[1];
    bus.divideby8  = div_cnt[2];
    bus.divideby16 = div_cnt[3];
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic wait_tick(input string tag, input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      cycle();
      if (bus.tick) seen = 1;
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  task automatic pulse_start(input logic [WIDTH-1:0] p);
    bus.period = p;
    bus.start  = 1'b1;
    cycle();
    bus.start  = 1'b0;
  endtask

  initial begin
    int ticks, pulses, last_t, first_p, prev_p;
    bit seen;
    n_cmp = 0; n_err = 0; cyc = 0;
    div_cnt = 4'd0;
    rst = 1'b0;
    bus.divideby2 = 0; bus.divideby4 = 0; bus.divideby8 = 0; bus.divideby16 = 0;
    bus.rate_sel = 2'd0; bus.period = '0;
    bus.start = 0; bus.stop = 0; bus.ack = 0;
    m_state = M_IDLE; m_count = 0; m_period = 0; m_prev_lvl = 4'b0;
    m_tick = 0; m_busy = 0; m_exp = 0; m_pulse = 0; m_ovr = 0;

    // Reset held with divider running
    run(3);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_busy",  32'(bus.busy),  32'd0);
    chk("rst_tick",  32'(bus.tick),  32'd0);
    rst = 1'b1;
    run(2);

`ifdef DIV_TICK_AUTO_RELOAD_EN
    // Periodic mode: period 2 on /4 -> expiry every 8 clk
    bus.rate_sel = 2'd1;
    pulse_start(8'd2);
    pulses = 0; first_p = -1; prev_p = -1;
    for (int i = 0; i < 60 && pulses < 3; i++) begin
      cycle();
      if (bus.expire_pulse) begin
        pulses++;
        if (prev_p >= 0) chk("ar_gap", 32'(cyc - prev_p), 32'd8);
        chk("ar_busy", 32'(bus.busy), 32'd1);
        chk("ar_overrun", 32'(bus.overrun), (pulses >= 2) ? 32'd1 : 32'd0);
        prev_p = cyc;
      end
    end
    chk("ar_pulses", 32'(pulses), 32'd3);
    bus.ack = 1'b1;
    cycle();
    bus.ack = 1'b0;
    chk("ar_ack_exp",  32'(bus.expired), 32'd0);
    chk("ar_ack_ovr",  32'(bus.overrun), 32'd0);
    chk("ar_ack_busy", 32'(bus.busy),    32'd1);
    bus.stop = 1'b1;
    cycle();
    bus.stop = 1'b0;
    chk("ar_stop", 32'(bus.busy), 32'd0);
`else
    // One-shot, /2, period 3
    bus.rate_sel = 2'd0;
    pulse_start(8'd3);
    chk("s2_busy", 32'(bus.busy),  32'd1);
    chk("s2_load", 32'(bus.count), 32'd3);
    ticks = 0; last_t = -1; seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle();
      if (bus.tick) begin
        if (last_t >= 0) chk("s2_tick_gap", 32'(cyc - last_t), 32'd2);
        last_t = cyc;
        ticks++;
      end
      if (bus.expire_pulse) seen = 1;
    end
    chk("s2_expiry_seen", 32'(seen),        32'd1);
    chk("s2_ticks",       32'(ticks),       32'd3);
    chk("s2_busy_fall",   32'(bus.busy),    32'd0);
    chk("s2_expired",     32'(bus.expired), 32'd1);
    chk("s2_count0",      32'(bus.count),   32'd0);
    cycle();
    chk("s2_pulse_width", 32'(bus.expire_pulse), 32'd0);
    run(3);
    chk("s2_sticky", 32'(bus.expired), 32'd1);
    bus.ack = 1'b1;
    cycle();
    bus.ack = 1'b0;
    chk("s2_ack", 32'(bus.expired), 32'd0);

    // /16, period 3, then switch to /2 before the last tick
    bus.rate_sel = 2'd3;
    pulse_start(8'd3);
    wait_tick("s3_tick1", 24);
    chk("s3_cnt2", 32'(bus.count), 32'd2);
    last_t = cyc;
    wait_tick("s3_tick2", 24);
    chk("s3_gap16", 32'(cyc - last_t), 32'd16);
    chk("s3_cnt1",  32'(bus.count), 32'd1);
    bus.rate_sel = 2'd0;
    wait_tick("s3_tick3", 4);
    chk("s3_expire", 32'(bus.expire_pulse), 32'd1);

    // period 0 expires on the first tick
    pulse_start(8'd0);
    wait_tick("s4_tick", 4);
    chk("s4_expire", 32'(bus.expire_pulse), 32'd1);

    // start + ack together in EXPIRED
    bus.period = 8'd6; bus.start = 1'b1; bus.ack = 1'b1;
    cycle();
    bus.start = 1'b0; bus.ack = 1'b0;
    chk("s6_busy",  32'(bus.busy),    32'd1);
    chk("s6_count", 32'(bus.count),   32'd6);
    chk("s6_exp",   32'(bus.expired), 32'd0);
    bus.stop = 1'b1;
    cycle();
    bus.stop = 1'b0;
`endif

    // stop coinciding with a tick in RUN
    bus.rate_sel = 2'd0;
    pulse_start(8'd5);
    wait_tick("s5_tick", 4);
    chk("s5_cnt4", 32'(bus.count), 32'd4);
    cycle();
    bus.stop = 1'b1;
    cycle();
    bus.stop = 1'b0;
    chk("s5_busy",  32'(bus.busy),         32'd0);
    chk("s5_count", 32'(bus.count),        32'd4);
    chk("s5_tick",  32'(bus.tick),         32'd1);
    chk("s5_nopul", 32'(bus.expire_pulse), 32'd0);

    // reset mid-run at count 5
    pulse_start(8'd9);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle();
      if (bus.count == 8'd5) seen = 1;
    end
    chk("s7_reach5", 32'(seen), 32'd1);
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    chk("s7_count", 32'(bus.count),        32'd0);
    chk("s7_busy",  32'(bus.busy),         32'd0);
    chk("s7_pulse", 32'(bus.expire_pulse), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      bus.start  = ($urandom_range(0, 29) == 0);
      bus.stop   = ($urandom_range(0, 79) == 0);
      bus.ack    = ($urandom_range(0, 9) == 0);
      bus.period = WIDTH'($urandom_range(0, 6));
      if ($urandom_range(0, 24) == 0) bus.rate_sel = 2'($urandom_range(0, 3));
      rst = ($urandom_range(0, 499) != 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
